traffic_light_ctrl: RTL and testbench

//   Moore FSM for a three-approach intersection: highway direction 1 (R1),

---
 rtl/traffic_light_pkg.sv | 16 +
 rtl/phase_timer.sv | 14 +
 rtl/traffic_light_ctrl.sv | 73 +++++++
 tb/tb_traffic_light_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared FSM state encoding and default phase durations for traffic_light_ctrl
package traffic_light_pkg;
  typedef enum logic [2:0] {
    R1_G = 3'd0,
    R1_Y = 3'd1,
    R2_G = 3'd2,
    R2_Y = 3'd3,
    F_G  = 3'd4,
    F_Y  = 3'd5
  } state_t;
  localparam int DEF_T_GREEN  = 20;
  localparam int DEF_T_YELLOW = 5;
  localparam int DEF_T_FG_MIN = 10;
  localparam int DEF_T_FG_MAX = 30;
  localparam int DEF_TW       = 8;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: TW-bit up counter cleared by rst or i_clr (ports: clk, rst, i_clr in; o_cnt out)
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  output logic [TW-1:0] o_cnt
);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: Moore R1/R2/farm-road light FSM (in: clk, rst, c sensor; out: R1G/Y/R, R2G/Y/R, FG/Y/R lamps)
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_FG_MIN = DEF_T_FG_MIN,
  parameter int T_FG_MAX = DEF_T_FG_MAX,
  parameter int TW       = DEF_TW
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  output logic R1G,
  output logic R1Y,
  output logic R1R,
  output logic R2G,
  output logic R2Y,
  output logic R2R,
  output logic FG,
  output logic FY,
  output logic FR
);
  localparam logic [TW-1:0] L_GREEN  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] L_YELLOW = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] L_FG_MIN = TW'(T_FG_MIN - 1);
  localparam logic [TW-1:0] L_FG_MAX = TW'(T_FG_MAX - 1);
  state_t        r_state;
  state_t        w_next;
  logic          r_req;
  logic [TW-1:0] w_timer;
  logic          w_clr;
  logic          w_g_done;
  logic          w_y_done;
  logic          w_fg_done;
  assign w_g_done  = w_timer == L_GREEN;
  assign w_y_done  = w_timer == L_YELLOW;
  assign w_fg_done = (w_timer >= L_FG_MIN && !c) || w_timer == L_FG_MAX;
  assign w_clr     = w_next != r_state;
  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_cnt (w_timer)
  );
  always_ff @(posedge clk) begin
    r_state <= rst ? R1_G : w_next;
    r_req   <= rst ? 1'b0 :
               (w_next == F_G && r_state != F_G) ? 1'b0 :
               (c && r_state != F_G) ? 1'b1 : r_req;
  end
  always_comb begin
    w_next = R1_G;
    case (r_state)
      R1_G:    w_next = w_g_done  ? R1_Y : R1_G;
      R1_Y:    w_next = w_y_done  ? R2_G : R1_Y;
      R2_G:    w_next = w_g_done  ? R2_Y : R2_G;
      R2_Y:    w_next = w_y_done  ? ((r_req || c) ? F_G : R1_G) : R2_Y;
      F_G:     w_next = w_fg_done ? F_Y : F_G;
      F_Y:     w_next = w_y_done  ? R1_G : F_Y;
      default: w_next = R1_G;
    endcase
  end
  assign R1G = r_state == R1_G;
  assign R1Y = r_state == R1_Y;
  assign R1R = !(R1G || R1Y);
  assign R2G = r_state == R2_G;
  assign R2Y = r_state == R2_Y;
  assign R2R = !(R2G || R2Y);
  assign FG  = r_state == F_G;
  assign FY  = r_state == F_Y;
  assign FR  = !(FG || FY);
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed self-checking bench for traffic_light_ctrl lamp sequencing
module tb_traffic_light_ctrl;
  localparam logic [8:0] L_R1G = 9'b100_001_001;
  localparam logic [8:0] L_R1Y = 9'b010_001_001;
  localparam logic [8:0] L_R2G = 9'b001_100_001;
  localparam logic [8:0] L_R2Y = 9'b001_010_001;
  localparam logic [8:0] L_FG  = 9'b001_001_100;
  localparam logic [8:0] L_FY  = 9'b001_001_010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c   = 1'b0;
  logic R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR;
  logic [8:0] lamps;
  int n_tests = 0;
  int n_fail  = 0;
  assign lamps = {R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR};
  always #5 clk = ~clk;
  traffic_light_ctrl dut (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .R1G (R1G),
    .R1Y (R1Y),
    .R1R (R1R),
    .R2G (R2G),
    .R2Y (R2Y),
    .R2R (R2R),
    .FG  (FG),
    .FY  (FY),
    .FR  (FR)
  );
  task automatic chk(input string tag, input int idx, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [8:0] exp, input int n);
    logic [8:0] inv;
    logic [8:0] act;
    for (int i = 0; i < n; i++) begin
      chk(tag, i, lamps, exp);
      inv = {6'd0, $countones({R1G, R1Y, R1R}) == 1, $countones({R2G, R2Y, R2R}) == 1, $countones({FG, FY, FR}) == 1};
      act = 9'(int'(!R1R) + int'(!R2R) + int'(!FR) <= 1);
      chk({tag, "_onehot"}, i, inv, 9'b000_000_111);
      chk({tag, "_one_active"}, i, act, 9'd1);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    c   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lamps", 0, lamps, L_R1G);
    chk("reset_req", 0, 9'(dut.r_req), 9'd0);
    rst = 1'b0;
    run("t1_r1g", L_R1G, 20);
    run("t2_r1y", L_R1Y, 5);
    run("t2_r2g", L_R2G, 20);
    run("t2_r2y", L_R2Y, 5);
    run("t2_r1g", L_R1G, 20);
    run("t2_r1y", L_R1Y, 5);
    run("t2_r2g", L_R2G, 20);
    run("t2_r2y", L_R2Y, 5);
    run("t3_r1g_a", L_R1G, 3);
    c = 1'b1;
    run("t3_r1g_pulse", L_R1G, 1);
    c = 1'b0;
    chk("t3_req_set", 0, 9'(dut.r_req), 9'd1);
    run("t3_r1g_b", L_R1G, 16);
    run("t3_r1y", L_R1Y, 5);
    run("t3_r2g", L_R2G, 20);
    run("t3_r2y", L_R2Y, 5);
    run("t3_fg", L_FG, 10);
    run("t3_fy", L_FY, 5);
    chk("t3_req_clr", 0, 9'(dut.r_req), 9'd0);
    run("t3_r1g", L_R1G, 20);
    run("t3_r1y", L_R1Y, 5);
    run("t3_r2g", L_R2G, 20);
    run("t3_r2y", L_R2Y, 5);
    c = 1'b1;
    run("t4_r1g_pulse", L_R1G, 1);
    c = 1'b0;
    run("t4_r1g", L_R1G, 19);
    run("t4_r1y", L_R1Y, 5);
    run("t4_r2g", L_R2G, 20);
    run("t4_r2y", L_R2Y, 5);
    c = 1'b1;
    run("t4_fg_c", L_FG, 14);
    c = 1'b0;
    run("t4_fg_tail", L_FG, 1);
    run("t4_fy", L_FY, 5);
    chk("t4_req", 0, 9'(dut.r_req), 9'd0);
    c = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run("t5_r1g", L_R1G, 20);
      run("t5_r1y", L_R1Y, 5);
      run("t5_r2g", L_R2G, 20);
      run("t5_r2y", L_R2Y, 5);
      run("t5_fg", L_FG, 30);
      run("t5_fy", L_FY, 5);
    end
    run("t6_r1g", L_R1G, 20);
    run("t6_r1y", L_R1Y, 5);
    run("t6_r2g", L_R2G, 20);
    run("t6_r2y", L_R2Y, 5);
    run("t6_fg", L_FG, 3);
    c   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_lamps", 0, lamps, L_R1G);
    chk("t6_rst_req", 0, 9'(dut.r_req), 9'd0);
    run("t6_post_r1g", L_R1G, 20);
    run("t6_post_r1y", L_R1Y, 5);
    run("t6_post_r2g", L_R2G, 20);
    run("t6_post_r2y", L_R2Y, 5);
    run("t6_post_nof", L_R1G, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
